// File: rtl/taylor_cos_horner_seq.sv
// -----------------------------------------------------------------------------
// taylor_cos_horner_seq
//
// Sequencer for the FP32 cosine Taylor polynomial
//    cos(x) ~= c0 + x^2*(c1 + x^2*(c2 + x^2*c3))
// evaluated by Horner's rule. The block does no floating-point arithmetic:
// it squares x and runs every Horner step on a shared external FP32 MAC
// (a*b + c) over a request/done handshake. Coefficients come from an external
// combinational inverse-factorial LUT addressed by coef_idx.
//
// Ports
//    clk, rst_n        clock, synchronous active-low reset
//    in_valid/in_ready input handshake, x_in = range-reduced FP32 angle
//    coef_idx, coef    LUT index out, LUT data back in the same cycle
//    mac_valid/ready   MAC request handshake, operands mac_a*mac_b+mac_c
//    mac_done          one-cycle pulse qualifying mac_result
//    out_valid/ready   output handshake, out_data = FP32 cos(x)
//    busy              high whenever the sequencer is not idle
//
// Parameters
//    TERMS  number of polynomial coefficients used (1..2**IDX_W)
//    IDX_W  width of the coefficient index
// -----------------------------------------------------------------------------
module taylor_cos_horner_seq #(
   parameter int TERMS = 4,
   parameter int IDX_W = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      x_in,
   output logic [IDX_W-1:0] coef_idx,
   input  logic [31:0]      coef,
   output logic             mac_valid,
   input  logic             mac_ready,
   output logic [31:0]      mac_a,
   output logic [31:0]      mac_b,
   output logic [31:0]      mac_c,
   input  logic             mac_done,
   input  logic [31:0]      mac_result,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_data,
   output logic             busy
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SQ_REQ,
      S_SQ_WAIT,
      S_HRN_REQ,
      S_HRN_WAIT,
      S_DONE
   } state_t;

   // Index of the highest coefficient, and of the first one folded in by a
   // Horner step. The second is meaningless (and unused) when TERMS == 1.
   localparam logic [IDX_W-1:0] LP_IDX_LAST   = IDX_W'(TERMS - 1);
   localparam logic [IDX_W-1:0] LP_IDX_SECOND = IDX_W'((TERMS >= 2) ? TERMS - 2 : 0);

   state_t           r_state;
   state_t           w_next;
   logic [31:0]      r_x;         // latched angle
   logic [31:0]      r_x2;        // x^2 returned by the MAC
   logic [31:0]      r_acc;       // Horner accumulator
   logic [IDX_W-1:0] r_coef_idx;  // doubles as the Horner step counter k

   assign coef_idx = r_coef_idx;

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   // NOTE: sequential state is written with non-blocking (<=) assignments so
   // every flop samples pre-edge values, independent of process ordering.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // ---------------------------------------------------------------------------
   // Next state and outputs. MAC operands and out_data are decoded from the
   // state and registers, so they hold still while a handshake is stalled and
   // read as zero whenever their valid is low.
   // ---------------------------------------------------------------------------
   // NOTE: every output gets a default before the case; a path that skips an
   // assignment would otherwise infer a latch.
   always_comb begin
      w_next    = r_state;
      in_ready  = 1'b0;
      mac_valid = 1'b0;
      mac_a     = 32'h0;
      mac_b     = 32'h0;
      mac_c     = 32'h0;
      out_valid = 1'b0;
      out_data  = 32'h0;
      busy      = 1'b1;

      case (r_state)
         S_IDLE: begin
            busy     = 1'b0;
            in_ready = 1'b1;
            if (in_valid) begin
               // A single-term polynomial is just c0: no MAC work at all.
               w_next = (TERMS == 1) ? S_DONE : S_SQ_REQ;
            end
         end

         S_SQ_REQ: begin
            mac_valid = 1'b1;
            mac_a     = r_x;
            mac_b     = r_x;
            if (mac_ready) begin
               w_next = S_SQ_WAIT;
            end
         end

         S_SQ_WAIT: begin
            if (mac_done) begin
               w_next = S_HRN_REQ;
            end
         end

         S_HRN_REQ: begin
            mac_valid = 1'b1;
            mac_a     = r_acc;
            mac_b     = r_x2;
            mac_c     = coef;   // LUT is combinational off r_coef_idx
            if (mac_ready) begin
               w_next = S_HRN_WAIT;
            end
         end

         S_HRN_WAIT: begin
            if (mac_done) begin
               w_next = (r_coef_idx == '0) ? S_DONE : S_HRN_REQ;
            end
         end

         S_DONE: begin
            out_valid = 1'b1;
            out_data  = r_acc;
            if (out_ready) begin
               w_next = S_IDLE;
            end
         end

         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Datapath registers
   //
   // r_coef_idx is pointed at the top coefficient as soon as x is accepted, so
   // the LUT output is already valid when the square returns and can seed the
   // accumulator. Each Horner step then counts it down to 0; it therefore
   // always rests at 0 in IDLE, which the single-term path relies on.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_x        <= 32'h0;
         r_x2       <= 32'h0;
         r_acc      <= 32'h0;
         r_coef_idx <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_x <= x_in;
                  if (TERMS == 1) begin
                     r_acc <= coef;
                  end else begin
                     r_coef_idx <= LP_IDX_LAST;
                  end
               end
            end

            S_SQ_WAIT: begin
               if (mac_done) begin
                  r_x2       <= mac_result;
                  r_acc      <= coef;
                  r_coef_idx <= LP_IDX_SECOND;
               end
            end

            S_HRN_WAIT: begin
               if (mac_done) begin
                  r_acc <= mac_result;
                  if (r_coef_idx != '0) begin
                     r_coef_idx <= r_coef_idx - IDX_W'(1);
                  end
               end
            end

            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_taylor_cos_horner_seq.sv
// -----------------------------------------------------------------------------
// tb_taylor_cos_horner_seq
//
// Bench for taylor_cos_horner_seq. Provides the coefficient LUT and an FP32
// MAC with programmable latency and request back-pressure, and a reference
// model that evaluates the Horner polynomial directly from the coefficients.
// A second instance with TERMS = 1 covers the no-MAC path.
// -----------------------------------------------------------------------------
module tb_taylor_cos_horner_seq;

   localparam int          TERMS = 4;
   localparam logic [31:0] ONE   = 32'h3F800000;
   localparam logic [31:0] COS1  = 32'h3F0A4FA5;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] c;
      logic [1:0]  idx;
   } txn_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // main DUT (TERMS = 4)
   logic        in_valid   = 1'b0;
   logic        in_ready;
   logic [31:0] x_in       = 32'h0;
   logic [1:0]  coef_idx;
   logic [31:0] coef;
   logic        mac_valid;
   logic        mac_ready  = 1'b0;
   logic [31:0] mac_a, mac_b, mac_c;
   logic        mac_done   = 1'b0;
   logic [31:0] mac_result = 32'h0;
   logic        out_valid;
   logic        out_ready  = 1'b0;
   logic [31:0] out_data;
   logic        busy;

   // single-term DUT
   logic        in_valid1  = 1'b0;
   logic        in_ready1;
   logic [31:0] x_in1      = 32'h0;
   logic [1:0]  coef_idx1;
   logic [31:0] coef1;
   logic        mac_valid1;
   logic [31:0] mac_a1, mac_b1, mac_c1;
   logic        out_valid1;
   logic        out_ready1 = 1'b0;
   logic [31:0] out_data1;
   logic        busy1;

   int n_checks = 0;
   int n_pass   = 0;

   // ---------------------------------------------------------------------------
   // Coefficients 1/0!, -1/2!, 1/4!, -1/6! and FP32 <-> real helpers
   // ---------------------------------------------------------------------------
   function automatic logic [31:0] lut(input logic [1:0] i);
      case (i)
         2'd0:    return 32'h3F800000;
         2'd1:    return 32'hBF000000;
         2'd2:    return 32'h3D2AAAAB;
         default: return 32'hBAB60B61;
      endcase
   endfunction

   assign coef  = lut(coef_idx);
   assign coef1 = lut(coef_idx1);

   function automatic real f2r(input logic [31:0] f);
      logic [63:0] d;
      if (f[30:0] == 31'd0) d = {f[31], 63'd0};
      else                  d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
      return $bitstoreal(d);
   endfunction

   // Round-to-nearest-even from double to FP32 (normal range only).
   function automatic logic [31:0] r2f(input real r);
      logic [63:0] d;
      logic [23:0] m;
      logic [10:0] e;
      logic        up;
      d = $realtobits(r);
      if (d[62:0] == 63'd0) return {d[63], 31'd0};
      up = d[28] && ((d[27:0] != 28'd0) || d[29]);
      m  = {1'b0, d[51:29]} + 24'(up);
      e  = d[62:52] - 11'd896 + 11'(m[23]);
      return {d[63], e[7:0], m[22:0]};
   endfunction

   function automatic logic [31:0] fma32(input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] c);
      return r2f(f2r(a) * f2r(b) + f2r(c));
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", tag, got, exp);
   endtask

   // ---------------------------------------------------------------------------
   // Reference model: expected MAC request list and result for one angle
   // ---------------------------------------------------------------------------
   txn_t        exp_txn[$];
   logic [31:0] exp_out[$];
   logic [31:0] x_q[$];

   task automatic model_push(input logic [31:0] x);
      logic [31:0] x2;
      logic [31:0] acc;
      x2 = fma32(x, x, 32'h0);
      exp_txn.push_back('{a: x, b: x, c: 32'h0, idx: 2'(TERMS - 1)});
      acc = lut(2'(TERMS - 1));
      for (int k = TERMS - 2; k >= 0; k--) begin
         exp_txn.push_back('{a: acc, b: x2, c: lut(2'(k)), idx: 2'(k)});
         acc = fma32(acc, x2, lut(2'(k)));
      end
      exp_out.push_back(acc);
   endtask

   // ---------------------------------------------------------------------------
   // DUT instances
   // ---------------------------------------------------------------------------
   taylor_cos_horner_seq #(.TERMS(TERMS), .IDX_W(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in),
      .coef_idx(coef_idx), .coef(coef),
      .mac_valid(mac_valid), .mac_ready(mac_ready),
      .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c),
      .mac_done(mac_done), .mac_result(mac_result),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .busy(busy)
   );

   taylor_cos_horner_seq #(.TERMS(1), .IDX_W(2)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid1), .in_ready(in_ready1), .x_in(x_in1),
      .coef_idx(coef_idx1), .coef(coef1),
      .mac_valid(mac_valid1), .mac_ready(1'b1),
      .mac_a(mac_a1), .mac_b(mac_b1), .mac_c(mac_c1),
      .mac_done(1'b0), .mac_result(32'h0),
      .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
      .busy(busy1)
   );

   // ---------------------------------------------------------------------------
   // Cycle driver: bench MAC, input feeder, output consumer and monitors.
   // Everything runs on the falling edge; a handshake seen here completes on
   // the following rising edge.
   // ---------------------------------------------------------------------------
   bit          rand_mode = 1'b0;
   int          stall_len = 0;
   int          out_stall = 0;
   bit          lat_chk   = 1'b0;
   bit          rst_req   = 1'b1;
   bit          post_rst_chk = 1'b0;
   bit          spur_chk  = 1'b0;
   int          cyc = 0, acc_cyc = 0, txn_since = 0, n_out = 0;
   int          mac_cnt = 0, req_age = 0, out_age = 0;
   bit          mac_stalled = 1'b0, out_stalled = 1'b0, out_seen = 1'b0;
   bit          t1_mac_seen = 1'b0;
   logic [31:0] mac_pend, hold_a, hold_b, hold_c, hold_out, last_out;

   initial begin : drive
      txn_t e;
      forever begin
         @(negedge clk);
         cyc++;
         if (mac_valid1) t1_mac_seen = 1'b1;

         mac_done = 1'b0;
         if (mac_cnt > 0) begin
            mac_cnt--;
            if (mac_cnt == 0) begin
               mac_done   = 1'b1;
               mac_result = mac_pend;
            end
         end

         if (spur_chk) begin
            check("spurious_done_busy", 32'(busy), 32'd0);
            check("spurious_done_in_ready", 32'(in_ready), 32'd1);
            spur_chk = 1'b0;
         end

         if (post_rst_chk) begin
            check("rst_in_ready", 32'(in_ready), 32'd1);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_mac_valid", 32'(mac_valid), 32'd0);
            check("rst_coef_idx", 32'(coef_idx), 32'd0);
            check("rst_mac_a", mac_a, 32'h0);
            check("rst_mac_b", mac_b, 32'h0);
            check("rst_mac_c", mac_c, 32'h0);
            check("rst_out_data", out_data, 32'h0);
            // stray pulse while idle must be ignored
            mac_done     = 1'b1;
            mac_result   = 32'hDEADBEEF;
            post_rst_chk = 1'b0;
            spur_chk     = 1'b1;
         end

         if (rst_req) begin
            rst_n        = 1'b0;
            rst_req      = 1'b0;
            mac_cnt      = 0;
            in_valid     = 1'b0;
            mac_ready    = 1'b0;
            out_ready    = 1'b0;
            mac_stalled  = 1'b0;
            out_stalled  = 1'b0;
            exp_txn.delete();
            exp_out.delete();
            post_rst_chk = 1'b1;
         end else begin
            rst_n = 1'b1;

            // MAC request side
            if (!mac_valid) req_age = 0;
            mac_ready = rand_mode ? ($urandom_range(0, 2) != 0) : (req_age >= stall_len);
            if (mac_valid && mac_stalled) begin
               check("mac_a_stable", mac_a, hold_a);
               check("mac_b_stable", mac_b, hold_b);
               check("mac_c_stable", mac_c, hold_c);
            end
            if (mac_valid && mac_ready) begin
               if (exp_txn.size() == 0) begin
                  check("mac_unexpected_request", 32'd1, 32'd0);
               end else begin
                  e = exp_txn.pop_front();
                  check("mac_a", mac_a, e.a);
                  check("mac_b", mac_b, e.b);
                  check("mac_c", mac_c, e.c);
                  check("coef_idx", 32'(coef_idx), 32'(e.idx));
               end
               mac_pend    = fma32(mac_a, mac_b, mac_c);
               mac_cnt     = rand_mode ? int'($urandom_range(1, 4)) : 3;
               txn_since++;
               mac_stalled = 1'b0;
            end else if (mac_valid) begin
               hold_a      = mac_a;
               hold_b      = mac_b;
               hold_c      = mac_c;
               mac_stalled = 1'b1;
               req_age++;
            end else begin
               mac_stalled = 1'b0;
            end

            // output side
            if (!out_valid) out_age = 0;
            out_ready = rand_mode ? ($urandom_range(0, 1) != 0) : (out_age >= out_stall);
            if (out_valid && !out_seen) begin
               out_seen = 1'b1;
               if (lat_chk) check("out_latency", 32'(cyc - acc_cyc), 32'd17);
            end
            if (out_valid && out_stalled) begin
               check("out_data_stable", out_data, hold_out);
               check("in_ready_while_done", 32'(in_ready), 32'd0);
            end
            if (out_valid && out_ready) begin
               if (exp_out.size() == 0) check("out_unexpected", 32'd1, 32'd0);
               else                     check("out_data", out_data, exp_out.pop_front());
               check("mac_txn_count", 32'(txn_since), 32'(TERMS));
               last_out    = out_data;
               n_out++;
               out_stalled = 1'b0;
            end else if (out_valid) begin
               hold_out    = out_data;
               out_stalled = 1'b1;
               out_age++;
            end else begin
               out_stalled = 1'b0;
            end

            // input side
            in_valid = (x_q.size() > 0) && (!rand_mode || $urandom_range(0, 1) == 1);
            x_in     = (x_q.size() > 0) ? x_q[0] : 32'h0;
            if (in_valid && in_ready) begin
               check("no_overlap", 32'(exp_out.size()), 32'd0);
               model_push(x_q.pop_front());
               acc_cyc   = cyc;
               out_seen  = 1'b0;
               txn_since = 0;
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Scenario sequencing
   // ---------------------------------------------------------------------------
   function automatic bit quiet();
      return !rst_req && !post_rst_chk && !spur_chk && (x_q.size() == 0) &&
             (exp_out.size() == 0) && !busy;
   endfunction

   task automatic wait_quiet(input string tag, input int budget);
      int n = 0;
      while (!quiet() && n < budget) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (!quiet()) check({"timeout_", tag}, 32'd1, 32'd0);
   endtask

   initial begin : main
      logic [31:0] res2;
      int          n_before;
      int          n;
      int unsigned diff;
      real         xr;

      wait_quiet("reset", 20);

      // zero angle, fixed latency 3, no back-pressure
      lat_chk = 1'b1;
      x_q.push_back(32'h0);
      wait_quiet("zero", 200);
      check("zero_result", last_out, ONE);
      lat_chk = 1'b0;

      // x = 1.0
      x_q.push_back(ONE);
      wait_quiet("one", 200);
      diff = (last_out > COS1) ? last_out - COS1 : COS1 - last_out;
      check("one_within_1ulp", 32'(diff <= 1), 32'd1);
      res2 = last_out;

      // request back-pressure
      stall_len = 5;
      x_q.push_back(ONE);
      wait_quiet("stall", 300);
      check("stall_same_result", last_out, res2);
      stall_len = 0;

      // output back-pressure with two back-to-back inputs
      out_stall = 4;
      n_before  = n_out;
      x_q.push_back(32'h3F000000);
      x_q.push_back(32'hBFC00000);
      wait_quiet("b2b", 400);
      check("b2b_outputs", 32'(n_out - n_before), 32'd2);
      out_stall = 0;

      // reset while the first Horner step is in flight
      n_before = n_out;
      x_q.push_back(ONE);
      n = 0;
      while (!(txn_since == 2 && !mac_valid && busy) && n < 100) begin
         @(negedge clk);
         #1;
         n++;
      end
      check("reached_hrn_wait", 32'(txn_since == 2 && !mac_valid && busy), 32'd1);
      rst_req = 1'b1;
      wait_quiet("midreset", 50);
      check("midreset_discard", 32'(n_out - n_before), 32'd0);

      // randomized angles, latencies and back-pressure
      rand_mode = 1'b1;
      n_before  = n_out;
      for (int i = 0; i < 12; i++) begin
         xr = real'(int'($urandom_range(0, 62800)) - 31400) / 10000.0;
         x_q.push_back(r2f(xr));
      end
      wait_quiet("random", 4000);
      check("random_outputs", 32'(n_out - n_before), 32'd12);
      rand_mode = 1'b0;

      // single-term instance: c0 straight through, no MAC traffic
      @(negedge clk);
      in_valid1 = 1'b1;
      x_in1     = ONE;
      check("t1_in_ready", 32'(in_ready1), 32'd1);
      @(negedge clk);
      in_valid1 = 1'b0;
      n = 1;
      while (!out_valid1 && n < 8) begin
         @(negedge clk);
         n++;
      end
      check("t1_out_valid", 32'(out_valid1), 32'd1);
      check("t1_latency_le2", 32'(n <= 2), 32'd1);
      check("t1_out_data", out_data1, ONE);
      out_ready1 = 1'b1;
      @(negedge clk);
      out_ready1 = 1'b0;
      check("t1_back_idle", 32'(in_ready1), 32'd1);
      check("t1_no_mac_request", 32'(t1_mac_seen), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
